// File: rtl/host_command_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : host_command_sequencer_if
// Description : Command, stats and result handshake bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface host_command_sequencer_if;
    logic [63:0] command_data;
    logic        command_ready;
    logic        command_wanted;
    logic [63:0] stats_data;
    logic        stats_ready_to_return;
    logic        stats_ready_to_accept;
    logic [31:0] result_data;
    logic        result_ready_to_return;
    logic        result_ready_to_accept;

    modport master (
        output command_data,
        output command_ready,
        input  command_wanted,
        input  stats_data,
        input  stats_ready_to_return,
        output stats_ready_to_accept,
        input  result_data,
        input  result_ready_to_return,
        output result_ready_to_accept
    );

    modport slave (
        input  command_data,
        input  command_ready,
        output command_wanted,
        output stats_data,
        output stats_ready_to_return,
        input  stats_ready_to_accept,
        output result_data,
        output result_ready_to_return,
        input  result_ready_to_accept
    );
endinterface
`default_nettype wire

// File: rtl/host_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : host_command_sequencer
// Description : Issues reset/config/start command words for one detection job,
//               forwards results, captures the stats word or times out.
// Revision    : 1.0 - initial release
// ============================================================================
module host_command_sequencer (
    input  wire                      clk,
    input  wire                      reset,
    input  wire                      go,
    input  wire               [59:0] cfg_width,
    input  wire               [59:0] cfg_height,
    input  wire               [59:0] cfg_scale,
    input  wire               [59:0] cfg_win,
    input  wire               [59:0] cfg_win_inv,
    input  wire               [59:0] cfg_stages,
    input  wire               [59:0] cfg_min_win,
    input  wire               [31:0] timeout_cycles,
    host_command_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic              [63:0] cycle_count,
    output logic              [15:0] result_count,
    output logic                     res_valid,
    output logic              [31:0] res_data
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_RST_CMD   = 3'd1;
    localparam logic [2:0] c_ST_CFG       = 3'd2;
    localparam logic [2:0] c_ST_START_CMD = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;
    localparam logic [2:0] c_ST_CAPTURE   = 3'd5;
    localparam logic [2:0] c_ST_FIN       = 3'd6;
    localparam logic [2:0] c_ST_ERR       = 3'd7;

    localparam logic [3:0] c_OP_RESET     = 4'd1;
    localparam logic [3:0] c_OP_START     = 4'd2;
    localparam logic [3:0] c_OP_CFG_BASE  = 4'd3;
    localparam logic [2:0] c_LAST_CFG_IDX = 3'd6;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [2:0]  r_cfg_idx;
    logic [31:0] r_watchdog;
    logic [31:0] r_timeout_cycles;
    logic [59:0] r_cfg_width, r_cfg_height, r_cfg_scale, r_cfg_win;
    logic [59:0] r_cfg_win_inv, r_cfg_stages, r_cfg_min_win;
    logic [59:0] w_cfg_payload;
    logic [63:0] w_cmd_data;
    logic        w_cmd_ready;
    logic        w_stats_acc;
    logic        w_res_acc;
    logic        w_xfer;
    logic        w_res_take;
    logic        w_wd_expire;

    assign w_xfer      = w_cmd_ready && bus.command_wanted;
    assign w_res_take  = w_res_acc && bus.result_ready_to_return;
    // A zero limit disables the watchdog entirely.
    assign w_wd_expire = (r_timeout_cycles != 32'd0) &&
                         (r_watchdog == (r_timeout_cycles - 32'd1));

    assign bus.command_data          = w_cmd_data;
    assign bus.command_ready         = w_cmd_ready;
    assign bus.stats_ready_to_accept = w_stats_acc;
    assign bus.result_ready_to_accept = w_res_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:      if (go) w_next_state = c_ST_RST_CMD;
            c_ST_RST_CMD:   if (w_xfer) w_next_state = c_ST_CFG;
            c_ST_CFG:       if (w_xfer && (r_cfg_idx == c_LAST_CFG_IDX)) w_next_state = c_ST_START_CMD;
            c_ST_START_CMD: if (w_xfer) w_next_state = c_ST_RUN;
            c_ST_RUN: begin
                // Stats arrival wins over a coincident watchdog expiry.
                if (bus.stats_ready_to_return) begin
                    w_next_state = c_ST_CAPTURE;
                end else if (w_wd_expire) begin
                    w_next_state = c_ST_ERR;
                end
            end
            c_ST_CAPTURE:   w_next_state = c_ST_FIN;
            c_ST_FIN:       w_next_state = c_ST_IDLE;
            c_ST_ERR:       w_next_state = c_ST_IDLE;
            default:        w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cfg_payload = 60'd0;
        case (r_cfg_idx)
            3'd0:    w_cfg_payload = r_cfg_width;
            3'd1:    w_cfg_payload = r_cfg_height;
            3'd2:    w_cfg_payload = r_cfg_scale;
            3'd3:    w_cfg_payload = r_cfg_win;
            3'd4:    w_cfg_payload = r_cfg_win_inv;
            3'd5:    w_cfg_payload = r_cfg_stages;
            3'd6:    w_cfg_payload = r_cfg_min_win;
            default: w_cfg_payload = 60'd0;
        endcase
    end

    always_comb begin
        w_cmd_ready = 1'b0;
        w_cmd_data  = 64'd0;
        w_stats_acc = 1'b0;
        w_res_acc   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE:      busy = 1'b0;
            c_ST_RST_CMD: begin
                w_cmd_ready = 1'b1;
                w_cmd_data  = {60'd0, c_OP_RESET};
            end
            c_ST_CFG: begin
                w_cmd_ready = 1'b1;
                w_cmd_data  = {w_cfg_payload, {1'b0, r_cfg_idx} + c_OP_CFG_BASE};
            end
            c_ST_START_CMD: begin
                w_cmd_ready = 1'b1;
                w_cmd_data  = {60'd0, c_OP_START};
            end
            c_ST_RUN:       w_res_acc   = 1'b1;
            c_ST_CAPTURE:   w_stats_acc = 1'b1;
            c_ST_FIN:       done        = 1'b1;
            c_ST_ERR:       done        = 1'b1;
            default:        busy        = 1'b1;
        endcase
    end

    // Job configuration is only ever consumed after a go, so it carries no reset.
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_IDLE) && go) begin
            r_cfg_width      <= cfg_width;
            r_cfg_height     <= cfg_height;
            r_cfg_scale      <= cfg_scale;
            r_cfg_win        <= cfg_win;
            r_cfg_win_inv    <= cfg_win_inv;
            r_cfg_stages     <= cfg_stages;
            r_cfg_min_win    <= cfg_min_win;
            r_timeout_cycles <= timeout_cycles;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_idx    <= 3'd0;
            r_watchdog   <= 32'd0;
            timeout      <= 1'b0;
            cycle_count  <= 64'd0;
            result_count <= 16'd0;
            res_valid    <= 1'b0;
            res_data     <= 32'd0;
        end else begin
            res_valid <= w_res_take;
            if (w_res_take) begin
                res_data <= bus.result_data;
                if (result_count != 16'hFFFF) begin
                    result_count <= result_count + 16'd1;
                end
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (go) begin
                        timeout      <= 1'b0;
                        cycle_count  <= 64'd0;
                        result_count <= 16'd0;
                    end
                end
                c_ST_RST_CMD:   if (w_xfer) r_cfg_idx  <= 3'd0;
                c_ST_CFG:       if (w_xfer) r_cfg_idx  <= r_cfg_idx + 3'd1;
                c_ST_START_CMD: if (w_xfer) r_watchdog <= 32'd0;
                c_ST_RUN: begin
                    r_watchdog <= r_watchdog + 32'd1;
                    if (w_next_state == c_ST_ERR) begin
                        timeout <= 1'b1;
                    end
                end
                c_ST_CAPTURE:   cycle_count <= bus.stats_data;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_host_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_command_sequencer
// Description : Table-driven and randomized job-level checks of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_command_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [59:0] cfg_width, cfg_height, cfg_scale, cfg_win, cfg_win_inv, cfg_stages, cfg_min_win;
    logic [31:0] timeout_cycles;
    logic        busy, done, timeout, res_valid;
    logic [63:0] cycle_count;
    logic [15:0] result_count;
    logic [31:0] res_data;

    host_command_sequencer_if bus ();

    host_command_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_scale      (cfg_scale),
        .cfg_win        (cfg_win),
        .cfg_win_inv    (cfg_win_inv),
        .cfg_stages     (cfg_stages),
        .cfg_min_win    (cfg_min_win),
        .timeout_cycles (timeout_cycles),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .result_count   (result_count),
        .res_valid      (res_valid),
        .res_data       (res_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] width;
        logic [59:0] stages;
        logic [31:0] tmo;
        int          stats_at;
        logic [63:0] sdata;
        logic [31:0] mask;
        int          mode;
        logic [31:0] base;
        logic        exp_to;
        logic [63:0] exp_cc;
        logic [15:0] exp_rc;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          n_sacc   = 0;
    logic [31:0] got_q[$];
    logic [63:0] got_cmd [9];
    int          cmd_cycles;

    // Pulse monitors: only this process writes these counters and the queue.
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (bus.stats_ready_to_accept) n_sacc <= n_sacc + 1;
        if (res_valid) got_q.push_back(res_data);
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Job outcome from the rules: stats at RUN cycle s wins unless the watchdog
    // fires strictly earlier at RUN cycle tmo.
    function automatic void predict(input logic [31:0] tmo, input int s,
                                    output logic to, output int run_len);
        if (s != 0 && (tmo == 32'd0 || 32'(s) <= tmo)) begin
            to = 1'b0; run_len = s;
        end else begin
            to = 1'b1; run_len = int'(tmo);
        end
    endfunction

    function automatic int accepted(input logic [31:0] mask, input int run_len);
        int n = 0;
        for (int k = 0; k < run_len; k++) n += int'(mask[k]);
        return n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, bus.command_ready, 0);
        chk({tag, "_cmd_data"}, bus.command_data, 0);
        chk({tag, "_stats_acc"}, bus.stats_ready_to_accept, 0);
        chk({tag, "_res_acc"}, bus.result_ready_to_accept, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_result_count"}, result_count, 0);
    endtask

    task automatic randomize_cfg_inputs();
        cfg_width   = {28'($urandom), 32'($urandom)};
        cfg_height  = {28'($urandom), 32'($urandom)};
        cfg_scale   = {28'($urandom), 32'($urandom)};
        cfg_win     = {28'($urandom), 32'($urandom)};
        cfg_win_inv = {28'($urandom), 32'($urandom)};
        cfg_stages  = {28'($urandom), 32'($urandom)};
        cfg_min_win = {28'($urandom), 32'($urandom)};
        timeout_cycles = $urandom;
    endtask

    task automatic run_job(input logic [59:0] width, input logic [59:0] stages, input bit rnd,
                           input logic [31:0] tmo, input int s, input logic [63:0] sdata,
                           input logic [31:0] mask, input int mode, input logic [31:0] base,
                           input logic exp_to, input logic [63:0] exp_cc, input logic [15:0] exp_rc);
        logic [59:0] c [7];
        logic [63:0] exp_w [9];
        logic [31:0] exp_q[$];
        logic        m_to, w;
        int          run_len, cyc, idx, nres, done0, sacc0, got0;
        for (int i = 0; i < 7; i++) c[i] = rnd ? {28'($urandom), 32'($urandom)} : 60'd0;
        c[0] = width;
        c[5] = stages;
        exp_w[0] = 64'h1;
        for (int i = 0; i < 7; i++) exp_w[i+1] = {c[i], 4'(i + 3)};
        exp_w[8] = 64'h2;
        predict(tmo, s, m_to, run_len);
        nres = 0;

        @(negedge clk);
        done0 = n_done; sacc0 = n_sacc; got0 = got_q.size();
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", bus.command_ready, 0);
        go = 1'b1;
        cfg_width = c[0]; cfg_height = c[1]; cfg_scale = c[2]; cfg_win = c[3];
        cfg_win_inv = c[4]; cfg_stages = c[5]; cfg_min_win = c[6];
        timeout_cycles = tmo;
        bus.command_wanted = 1'b0;
        bus.stats_ready_to_return = 1'b0;
        bus.result_ready_to_return = 1'b0;

        idx = 0; cyc = 0;
        while (idx < 9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk($sformatf("cmd_ready[%0d]", idx), bus.command_ready, 1);
            chk($sformatf("cmd_data[%0d]", idx), bus.command_data, exp_w[idx]);
            chk("busy_cmd", busy, 1);
            chk("res_acc_cmd", bus.result_ready_to_accept, 0);
            go = 1'($urandom_range(0, 1));
            randomize_cfg_inputs();
            bus.result_ready_to_return = 1'($urandom_range(0, 1));
            bus.result_data = $urandom;
            w = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            bus.command_wanted = w;
            if (w) begin
                got_cmd[idx] = bus.command_data;
                idx++;
            end
        end
        cmd_cycles = cyc;
        if (idx < 9) begin
            chk("cmd_phase_bound", 64'(idx), 64'd9);
            go = 1'b0;
            return;
        end

        for (int k = 1; k <= run_len; k++) begin
            @(negedge clk);
            chk("cmd_ready_run", bus.command_ready, 0);
            chk("res_acc_run", bus.result_ready_to_accept, 1);
            chk("done_run", done, 0);
            go = 1'($urandom_range(0, 1));
            bus.command_wanted = 1'($urandom_range(0, 1));
            bus.result_ready_to_return = mask[k-1];
            if (mask[k-1]) begin
                bus.result_data = base + 32'(nres);
                exp_q.push_back(base + 32'(nres));
                nres++;
            end else begin
                bus.result_data = $urandom;
            end
            bus.stats_ready_to_return = (s != 0 && k >= s);
            bus.stats_data = (s != 0 && k >= s) ? sdata : {$urandom, $urandom};
        end

        @(negedge clk);
        go = 1'b0;
        bus.result_ready_to_return = 1'($urandom_range(0, 1));
        bus.result_data = $urandom;
        chk("res_acc_tail", bus.result_ready_to_accept, 0);
        if (!m_to) begin
            chk("stats_acc_capture", bus.stats_ready_to_accept, 1);
            chk("done_capture", done, 0);
            @(negedge clk);
            bus.stats_ready_to_return = 1'b0;
            bus.stats_data = {$urandom, $urandom};
            chk("done_fin", done, 1);
            chk("stats_acc_fin", bus.stats_ready_to_accept, 0);
            chk("cycle_count_fin", cycle_count, exp_cc);
            chk("timeout_fin", timeout, 0);
        end else begin
            chk("done_err", done, 1);
            chk("timeout_err", timeout, 1);
            chk("cycle_count_err", cycle_count, exp_cc);
            chk("busy_err", busy, 1);
        end

        @(negedge clk);
        bus.result_ready_to_return = 1'b0;
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("timeout_final", timeout, exp_to);
        chk("result_count", result_count, exp_rc);
        chk("cycle_count_final", cycle_count, exp_cc);
        chk("done_pulses", 64'(n_done - done0), 64'd1);
        chk("stats_pulses", 64'(n_sacc - sacc0), m_to ? 64'd0 : 64'd1);
        chk("res_pulses", 64'(got_q.size() - got0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (got0 + i) < got_q.size(); i++)
            chk($sformatf("res_data[%0d]", i), got_q[got0+i], exp_q[i]);
    endtask

    initial begin
        vec_t        vecs [7];
        logic        m_to;
        int          run_len, s, nreq;
        logic [31:0] tmo, mask;
        logic [63:0] sdata;

        //        width   stages tmo  s  sdata                   mask     mode base     to  cc                      rc
        vecs[0] = '{60'd640, 60'd20, 32'd0,  5, 64'd1234,              32'h07,  0, 32'h0A, 1'b0, 64'd1234,              16'd3};
        vecs[1] = '{60'd1,   60'd2,  32'd5,  0, 64'd0,                 32'h00,  0, 32'h10, 1'b1, 64'd0,                 16'd0};
        vecs[2] = '{60'd3,   60'd4,  32'd4,  4, 64'd99,                32'h0F,  0, 32'h20, 1'b0, 64'd99,                16'd4};
        vecs[3] = '{60'd77,  60'd88, 32'd0,  2, 64'd7,                 32'h02,  1, 32'h30, 1'b0, 64'd7,                 16'd1};
        vecs[4] = '{60'd5,   60'd6,  32'd1,  0, 64'd0,                 32'h03,  0, 32'h40, 1'b1, 64'd0,                 16'd1};
        vecs[5] = '{60'd9,   60'd10, 32'd3,  6, 64'd55,                32'h1F,  2, 32'h50, 1'b1, 64'd0,                 16'd3};
        vecs[6] = '{60'd11,  60'd12, 32'd10, 7, 64'hDEAD_BEEF_0123_4567, 32'h55, 2, 32'h60, 1'b0, 64'hDEAD_BEEF_0123_4567, 16'd4};

        reset = 1'b1; go = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_scale = '0; cfg_win = '0;
        cfg_win_inv = '0; cfg_stages = '0; cfg_min_win = '0; timeout_cycles = '0;
        bus.command_wanted = 1'b0; bus.stats_data = '0; bus.stats_ready_to_return = 1'b0;
        bus.result_data = '0; bus.result_ready_to_return = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].width, vecs[v].stages, 1'b0, vecs[v].tmo, vecs[v].stats_at,
                    vecs[v].sdata, vecs[v].mask, vecs[v].mode, vecs[v].base,
                    vecs[v].exp_to, vecs[v].exp_cc, vecs[v].exp_rc);
            if (v == 0) begin
                chk("w0", got_cmd[0], 64'h1);
                chk("w1", got_cmd[1], 64'h2803);
                chk("w2", got_cmd[2], 64'h4);
                chk("w3", got_cmd[3], 64'h5);
                chk("w4", got_cmd[4], 64'h6);
                chk("w5", got_cmd[5], 64'h7);
                chk("w6", got_cmd[6], 64'h148);
                chk("w7", got_cmd[7], 64'h9);
                chk("w8", got_cmd[8], 64'h2);
                chk("cmd_cycles", 64'(cmd_cycles), 64'd9);
            end
        end

        // Reset while CFG index 3 (opcode 6) is on the bus.
        @(negedge clk);
        go = 1'b1; cfg_width = 60'd640; bus.command_wanted = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_ready", bus.command_ready, 1);
        chk("pre_reset_opcode", 64'(bus.command_data[3:0]), 64'd6);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midcmd");
        reset = 1'b0;
        bus.command_wanted = 1'b0;
        run_job(60'd640, 60'd20, 1'b1, 32'd0, 3, 64'd42, 32'h5, 0, 32'h100, 1'b0, 64'd42, 16'd2);

        for (int r = 0; r < 25; r++) begin
            tmo   = 32'($urandom_range(0, 12));
            s     = int'($urandom_range(0, 12));
            if (tmo == 32'd0 && s == 0) s = 3;
            sdata = {$urandom, $urandom};
            mask  = $urandom;
            predict(tmo, s, m_to, run_len);
            nreq  = accepted(mask, run_len);
            run_job({28'($urandom), 32'($urandom)}, {28'($urandom), 32'($urandom)}, 1'b1,
                    tmo, s, sdata, mask, int'($urandom_range(0, 2)), $urandom,
                    m_to, m_to ? 64'd0 : sdata, 16'(nreq));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/host_command_sequencer.md
HOST_COMMAND_SEQUENCER -- requirements
Module: host_command_sequencer

Interface
REQ-001 SHALL have ports clk (in, 1, rising-edge clock) and reset (in, 1); one clock, reset synchronous and active-high.
REQ-002 SHALL have go (in, 1): single-cycle request to run one detection job; sampled only in IDLE.
REQ-003 SHALL have cfg_width, cfg_height, cfg_scale, cfg_win, cfg_win_inv, cfg_stages, cfg_min_win (in, 60 each): payloads for opcodes 3,4,5,6,7,8,9 respectively; latched on the accepted go.
REQ-004 SHALL have timeout_cycles (in, 32): RUN-state watchdog limit; latched on the accepted go.
REQ-005 SHALL have command_data (out, 64) and command_ready (out, 1): command word and its valid flag.
REQ-006 SHALL have command_wanted (in, 1): consumer accepts the word this cycle.
REQ-007 SHALL have stats_data (in, 64), stats_ready_to_return (in, 1) and stats_ready_to_accept (out, 1).
REQ-008 SHALL have result_data (in, 32), result_ready_to_return (in, 1) and result_ready_to_accept (out, 1).
REQ-009 SHALL have busy (out, 1), done (out, 1 pulse), timeout (out, 1 sticky), cycle_count (out, 64), result_count (out, 16), res_valid (out, 1) and res_data (out, 32).

Function
REQ-010 Command word SHALL be {payload[59:0], opcode[3:0]}; the payload is zero for opcodes 1 and 2.
REQ-011 A command transfer SHALL occur on a cycle where command_ready && command_wanted; command_data SHALL be held stable while command_ready=1 and command_wanted=0.
REQ-012 The FSM SHALL have states IDLE, RST_CMD, CFG, START_CMD, RUN, CAPTURE, FIN and ERR.
REQ-013 IDLE: go=1 SHALL latch the cfg_* and timeout_cycles inputs, clear timeout, cycle_count and result_count, and move to RST_CMD.
REQ-014 RST_CMD SHALL present opcode 1; on transfer it SHALL move to CFG with index 0.
REQ-015 CFG SHALL present opcodes 3..9 in ascending order, one per transfer; the transfer of opcode 9 SHALL move to START_CMD.
REQ-016 START_CMD SHALL present opcode 2; on transfer it SHALL move to RUN and clear the watchdog counter.
REQ-017 With command_wanted tied high, RST_CMD through START_CMD SHALL take exactly 9 cycles, one word per cycle, with no bubbles.
REQ-018 command_ready SHALL be 1 only in RST_CMD, CFG and START_CMD.
REQ-019 RUN SHALL hold result_ready_to_accept=1.
REQ-020 Each cycle with result_ready_to_return && result_ready_to_accept SHALL register res_data=result_data and res_valid=1 on the next cycle, and SHALL increment result_count, saturating at 16'hFFFF.
REQ-021 RUN SHALL increment the 32-bit watchdog every cycle; when watchdog == timeout_cycles-1 and stats_ready_to_return=0, it SHALL move to ERR.
REQ-022 timeout_cycles=0 SHALL disable the watchdog.
REQ-023 RUN with stats_ready_to_return=1 SHALL move to CAPTURE; this takes priority over a watchdog expiry in the same cycle.
REQ-024 A result accepted in the same cycle as that transition SHALL still be counted and forwarded.
REQ-025 CAPTURE SHALL drive stats_ready_to_accept=1 for exactly one cycle, latch cycle_count=stats_data, and move to FIN.
REQ-026 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-027 ERR SHALL set timeout=1, pulse done=1 for one cycle, leave cycle_count at 0, and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 go while busy SHALL be ignored.
REQ-030 Results arriving outside RUN SHALL NOT be accepted; result_ready_to_accept SHALL be 0 outside RUN.
REQ-031 res_valid SHALL be a one-cycle pulse per accepted result, with no internal buffering beyond one register stage.

Reset
REQ-032 reset=1 SHALL force IDLE in any state, including mid-command with command_ready=1; no further command word is presented.
REQ-033 On reset, outputs SHALL be: command_ready=0, command_data=0, stats_ready_to_accept=0, result_ready_to_accept=0, busy=0, done=0, timeout=0, res_valid=0, res_data=0, cycle_count=0, result_count=0.
REQ-034 Latched cfg_* values SHALL NOT require reset.

Verification
REQ-035 command_wanted=1, go with cfg_width=640, cfg_stages=20 -> cycles 1..9 present 64'h1, 64'h2803, then 4,5,6,7,64'h148, 9, then 64'h2; RUN is entered on cycle 10.
REQ-036 command_wanted toggling 1/0 during CFG -> every word is held while command_wanted=0, and exactly 9 transfers occur in order.
REQ-037 In RUN, 3 results 0xA,0xB,0xC, then stats_ready_to_return with stats_data=1234 -> res_valid pulses 3 times with matching res_data, result_count=3, one stats_ready_to_accept pulse, cycle_count=1234, one done pulse.
REQ-038 timeout_cycles=5 and no stats -> ERR after 5 RUN cycles, timeout=1, one done pulse, busy=0 next cycle.
REQ-039 stats_ready_to_return and watchdog expiry in the same cycle -> CAPTURE is taken and timeout=0.
REQ-040 reset asserted during CFG index 3 -> next cycle all outputs at reset values; a following go restarts the sequence from opcode 1.
